// File: rtl/board_generator_if.sv
// board_generator_if: fill request, seeding controls and the cell-write stream
// between board_generator and the INITIAL_BOARD storage it fills.
interface board_generator_if;
    logic        gen_req;
    logic [4:0]  size;
    logic [3:0]  color_num;
    logic [15:0] seed_in;
    logic        seed_load;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [4:0]  wr_col;
    logic [2:0]  wr_color;
    logic        busy;
    logic        done;
    logic        board_valid;
    modport master (
        output gen_req, size, color_num, seed_in, seed_load,
        input  wr_en, wr_row, wr_col, wr_color, busy, done, board_valid
    );
    modport slave (
        input  gen_req, size, color_num, seed_in, seed_load,
        output wr_en, wr_row, wr_col, wr_color, busy, done, board_valid
    );
endinterface

// File: rtl/board_generator.sv
// board_generator: fills an SxS board row-major with LFSR colors, using rejection
// sampling with a bounded modulo fallback so every cell is written exactly once.
module board_generator #(
    parameter int          MAX_SIZE     = 26,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    board_generator_if.slave gen
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
    state_e        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          req_q;
    logic [4:0]    row_q, row_d, col_q, col_d, size_q, size_d;
    logic [3:0]    colors_q, colors_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [2:0]    wr_color_q, wr_color_d;
    logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [15:0]   lfsr_step;
    logic [2:0]    cand, color;
    logic          in_range, accept, start, row_end, last;
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand      = lfsr_q[2:0];
    assign in_range  = {1'b0, cand} < colors_q;
    assign accept    = in_range || retry_q == RW'(MAX_RETRY);
    // Fallback only triggers for out-of-range draws, so modulo keeps it below C.
    assign color     = in_range ? cand : 3'({1'b0, cand} % colors_q);
    assign start     = gen.gen_req && !req_q;
    assign row_end   = col_q == size_q - 5'd1;
    assign last      = row_end && row_q == size_q - 5'd1;
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        row_d      = row_q;
        col_d      = col_q;
        size_d     = size_q;
        colors_d   = colors_q;
        retry_d    = retry_q;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_color_d = wr_color_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                lfsr_d = !gen.seed_load ? lfsr_step : (gen.seed_in == 16'h0000 ? SEED_DEFAULT : gen.seed_in);
                if (start) begin
                    size_d   = gen.size < 5'd2 ? 5'd2 : (gen.size > 5'(MAX_SIZE) ? 5'(MAX_SIZE) : gen.size);
                    colors_d = gen.color_num < 4'd2 ? 4'd2 : (gen.color_num > 4'd8 ? 4'd8 : gen.color_num);
                    row_d    = 5'd0;
                    col_d    = 5'd0;
                    retry_d  = '0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                lfsr_d  = lfsr_step;
                retry_d = accept ? '0 : retry_q + RW'(1);
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_row_d   = row_q;
                    wr_col_d   = col_q;
                    wr_color_d = color;
                    col_d      = row_end ? 5'd0 : col_q + 5'd1;
                    row_d      = row_end ? row_q + 5'd1 : row_q;
                    state_d    = last ? DONE : FILL;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_DEFAULT;
            req_q      <= 1'b0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            size_q     <= 5'd2;
            colors_q   <= 4'd2;
            retry_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= 5'd0;
            wr_col_q   <= 5'd0;
            wr_color_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            req_q      <= gen.gen_req;
            row_q      <= row_d;
            col_q      <= col_d;
            size_q     <= size_d;
            colors_q   <= colors_d;
            retry_q    <= retry_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_color_q <= wr_color_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end
    assign gen.wr_en       = wr_en_q;
    assign gen.wr_row      = wr_row_q;
    assign gen.wr_col      = wr_col_q;
    assign gen.wr_color    = wr_color_q;
    assign gen.busy        = busy_q;
    assign gen.done        = done_q;
    assign gen.board_valid = valid_q;
endmodule
